// File: rtl/alu_pkg.sv
// Shared ALU shifter definitions.
//   shift_op_e      : 2-bit shift operation code (SLL, SRL, SRA, ROL)
//   shift_payload_t : per-stage payload at the ALU datapath width
//   num_stages()    : pipeline depth for a given level count and levels/stage
package alu_pkg;

    localparam int ALU_WIDTH = 32;
    localparam int ALU_SHW   = $clog2(ALU_WIDTH);

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } shift_op_e;

    // What travels between stages: partially shifted data, the op, the
    // operand's original sign bit (SRA fill), the amount bits not yet
    // consumed, and the sticky SLL overflow accumulator.
    typedef struct packed {
        logic [ALU_WIDTH-1:0] data;
        shift_op_e            op;
        logic                 sign;
        logic [ALU_SHW-1:0]   amt_rem;
        logic                 of_acc;
    } shift_payload_t;

    function automatic int num_stages(input int shw, input int lvl_per_st);
        return (shw + lvl_per_st - 1) / lvl_per_st;
    endfunction

endpackage

// File: rtl/pipelined_shifter_shift_stage.sv
// One registered stage of the log-depth shifter.
// Applies LVL_N shift levels (levels LVL_LO .. LVL_LO+LVL_N-1, level i
// shifting by 2^i when amt bit i is set), then registers the payload.
// Ports:
//   clk, rst (async, active-high), flush (sync, kills the held beat)
//   in_valid/in_ready   : upstream handshake
//   in_data, in_op, in_sign, in_amt, in_of : incoming payload
//   out_valid/out_ready : downstream handshake
//   out_data, out_op, out_sign, out_amt, out_of : registered payload
//   out_zero            : registered out_data == 0 (only driven when IS_LAST)
// Handshake: a beat moves when valid && ready at the same rising edge.
// The stage accepts when it is empty or its held beat is leaving, so
// bubbles collapse and in_ready never depends on in_valid.
module shift_stage
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHW     = 5,
    parameter int LVL_LO  = 0,
    parameter int LVL_N   = 2,
    parameter bit IS_LAST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             in_sign,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_of,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_op,
    output logic             out_sign,
    output logic [SHW-1:0]   out_amt,
    output logic             out_of,
    output logic             out_zero
);

    localparam logic [WIDTH-1:0] ONES = '1;

    shift_op_e        op;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] top_mask;
    logic [SHW-1:0]   lvl_mask;
    logic [SHW-1:0]   amt;
    logic             of;

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;
    logic [1:0]       op_d, op_q;
    logic             sign_d, sign_q;
    logic [SHW-1:0]   amt_d, amt_q;
    logic             of_d, of_q;
    logic             zero_d, zero_q;

    assign op = shift_op_e'(in_op);

    // Combinational shift levels for this stage.
    always_comb begin
        data     = in_data;
        of       = in_of;
        amt      = in_amt;
        top_mask = '0;
        lvl_mask = '0;
        for (int j = 0; j < LVL_N; j++) begin
            lvl_mask = SHW'(1) << (LVL_LO + j);
            if ((in_amt & lvl_mask) != '0) begin
                // Top s+1 bits of the current data: they must all match for
                // the left shift by s to keep the signed value. Consecutive
                // levels overlap on one bit, so the checks chain into the
                // exact "a[W-1 : W-1-amt] all equal" test.
                top_mask = ~(ONES >> ((1 << (LVL_LO + j)) + 1));
                case (op)
                    SH_SLL: begin
                        if (((data & top_mask) != '0) && ((data & top_mask) != top_mask))
                            of = 1'b1;
                        data = data << (1 << (LVL_LO + j));
                    end
                    SH_SRL: data = data >> (1 << (LVL_LO + j));
                    SH_SRA: data = (data >> (1 << (LVL_LO + j)))
                                 | (in_sign ? ~(ONES >> (1 << (LVL_LO + j))) : '0);
                    default: data = (data << (1 << (LVL_LO + j)))
                                  | (data >> (WIDTH - (1 << (LVL_LO + j))));
                endcase
                amt = amt & ~lvl_mask;
            end
        end
    end

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        op_d    = op_q;
        sign_d  = sign_q;
        amt_d   = amt_q;
        of_d    = of_q;
        zero_d  = zero_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = data;
                op_d   = in_op;
                sign_d = in_sign;
                amt_d  = amt;
                of_d   = of;
                zero_d = IS_LAST ? (data == '0) : 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
            amt_q   <= '0;
            of_q    <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            amt_q   <= amt_d;
            of_q    <= of_d;
            zero_q  <= zero_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_op    = op_q;
    assign out_sign  = sign_q;
    assign out_amt   = amt_q;
    assign out_of    = of_q;
    assign out_zero  = zero_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined shifter for the 32-bit signed ALU datapath: SLL, SRL, SRA, ROL,
// with an exact signed-overflow flag on SLL. Log-depth shifter split into
// NST = ceil(log2(WIDTH)/LVL_PER_ST) registered stages; latency NST cycles.
// Ports:
//   clk, rst (async, active-high), flush (sync, drops every in-flight op
//   and any beat offered in the same cycle)
//   in_valid/in_ready, in_a, in_amt, in_op : operand beat
//   out_valid/out_ready, out_y, out_of, out_zero : result beat
// Handshake: a beat transfers on a rising edge where valid && ready. Results
// stay stable while out_valid && !out_ready. in_ready depends on out_ready
// through the stage chain, never on in_valid.
module pipelined_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int LVL_PER_ST = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_y,
    output logic                     out_of,
    output logic                     out_zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int NST = num_stages(SHW, LVL_PER_ST);

    // Index k is the input of stage k; index NST is the pipeline output.
    logic             v_w    [NST+1];
    logic             r_w    [NST+1];
    logic [WIDTH-1:0] data_w [NST+1];
    logic [1:0]       op_w   [NST+1];
    logic             sign_w [NST+1];
    logic [SHW-1:0]   amt_w  [NST+1];
    logic             of_w   [NST+1];
    logic             zero_w [NST];

    assign v_w[0]    = in_valid;
    assign in_ready  = r_w[0];
    assign data_w[0] = in_a;
    assign op_w[0]   = in_op;
    assign sign_w[0] = in_a[WIDTH-1];
    assign amt_w[0]  = in_amt;
    assign of_w[0]   = 1'b0;

    assign r_w[NST]  = out_ready;
    assign out_valid = v_w[NST];
    assign out_y     = data_w[NST];
    assign out_of    = of_w[NST];   // only SLL ever sets the accumulator
    assign out_zero  = zero_w[NST-1];

    for (genvar k = 0; k < NST; k++) begin : g_stage
        localparam int LO = k * LVL_PER_ST;
        localparam int N  = (SHW - LO < LVL_PER_ST) ? (SHW - LO) : LVL_PER_ST;

        shift_stage #(
            .WIDTH   (WIDTH),
            .SHW     (SHW),
            .LVL_LO  (LO),
            .LVL_N   (N),
            .IS_LAST (k == NST - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_valid  (v_w[k]),
            .in_ready  (r_w[k]),
            .in_data   (data_w[k]),
            .in_op     (op_w[k]),
            .in_sign   (sign_w[k]),
            .in_amt    (amt_w[k]),
            .in_of     (of_w[k]),
            .out_valid (v_w[k+1]),
            .out_ready (r_w[k+1]),
            .out_data  (data_w[k+1]),
            .out_op    (op_w[k+1]),
            .out_sign  (sign_w[k+1]),
            .out_amt   (amt_w[k+1]),
            .out_of    (of_w[k+1]),
            .out_zero  (zero_w[k])
        );
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter (WIDTH=32, LVL_PER_ST=2, latency 3).
// Results are predicted by a plain-arithmetic model of each shift op and
// matched in order through an expected queue.
module tb_pipelined_shifter;

    localparam int W = 32;
    localparam longint S32_MAX = 64'sd2147483647;
    localparam longint S32_MIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [4:0]    in_amt;
    logic [1:0]    in_op;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_y;
    logic          out_of;
    logic          out_zero;

    pipelined_shifter #(.WIDTH(W), .LVL_PER_ST(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_of    (out_of),
        .out_zero  (out_zero)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    // Returns {y, of, zero}.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [4:0] amt,
                                          input logic [1:0] op);
        logic [31:0] y;
        logic        of;
        logic [63:0] dbl;
        longint      sa;
        longint      p;
        of = 1'b0;
        case (op)
            2'b00: begin
                y  = a << amt;
                sa = longint'($signed(a));
                p  = sa * (longint'(1) << amt);
                of = (p > S32_MAX) || (p < S32_MIN);
            end
            2'b01: y = a >> amt;
            2'b10: y = $signed(a) >>> amt;
            default: begin
                dbl = {a, a} << amt;
                y   = dbl[63:32];
            end
        endcase
        return {y, of, (y == 32'd0)};
    endfunction

    // ---------------- scoreboard ----------------
    logic [33:0] exp_q[$];
    int n_out   = 0;
    int run     = 0;
    int max_run = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            run = 0;
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    check(out_ready ? "result" : "hold",
                          64'({out_y, out_of, out_zero}), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (out_valid && out_ready) begin
                n_out++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model(in_a, in_amt, in_op));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic rand_beat();
        case ($urandom_range(0, 3))
            0: in_a = $urandom;
            1: in_a = 32'($urandom_range(0, 15));
            2: in_a = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: in_a = 32'h8000_0000 | 32'($urandom_range(0, 255));
        endcase
        case ($urandom_range(0, 3))
            0: in_amt = 5'd0;
            1: in_amt = 5'd31;
            default: in_amt = 5'($urandom_range(0, 31));
        endcase
        in_op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    // One op into an empty pipe; checks latency and the result directly.
    task automatic run_latency(input string tag, input logic [31:0] a, input logic [4:0] amt,
                               input logic [1:0] op, input logic [31:0] ey,
                               input logic eof, input logic ez);
        int n;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a = a; in_amt = amt; in_op = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(3));
        check({tag, "_y"}, 64'(out_y), 64'(ey));
        check({tag, "_of"}, 64'(out_of), 64'(eof));
        check({tag, "_zero"}, 64'(out_zero), 64'(ez));
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc;
        int n0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
        in_a = '0; in_amt = '0; in_op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_out_y", 64'(out_y), 64'(0));
        check("reset_out_of", 64'(out_of), 64'(0));
        check("reset_out_zero", 64'(out_zero), 64'(0));
        check("reset_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;

        // Directed corner cases.
        run_latency("sll31",   32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b1, 1'b0);
        run_latency("sra4",    32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000, 1'b0, 1'b0);
        run_latency("srl4",    32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000, 1'b0, 1'b0);
        run_latency("rol1",    32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003, 1'b0, 1'b0);
        run_latency("sll_neg", 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000, 1'b0, 1'b0);
        run_latency("sll_zero",32'h0000_0002, 5'd31, 2'b00, 32'h0000_0000, 1'b1, 1'b1);
        run_latency("sll_amt0",32'h4000_0000, 5'd0,  2'b00, 32'h4000_0000, 1'b0, 1'b0);
        run_latency("sll_of1", 32'h4000_0000, 5'd1,  2'b00, 32'h8000_0000, 1'b1, 1'b0);

        // Back-to-back: 8 ops, 8 results on consecutive cycles.
        max_run = 0;
        n0 = n_out;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            rand_beat();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_drain("b2b_drain", 20);
        check("b2b_count", 64'(n_out - n0), 64'(8));
        check("b2b_consecutive", 64'(max_run), 64'(8));

        // Stall: out_ready low for 5 cycles with in_valid high.
        n0 = n_out;
        acc = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            rand_beat();
            #1;
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        check("stall_accepts", 64'(acc), 64'(3));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        wait_drain("stall_drain", 20);
        check("stall_count", 64'(n_out - n0), 64'(3));

        // Flush with two ops in flight plus a same-cycle beat.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            rand_beat();
            @(posedge clk); #1;
        end
        n0 = n_out;
        flush = 1'b1;
        in_valid = 1'b1;
        rand_beat();
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'(1));
        check("flush_out_valid", 64'(out_valid), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check("flush_quiet", 64'(n_out - n0), 64'(0));
        run_latency("post_flush", 32'h0000_00F0, 5'd4, 2'b01, 32'h0000_000F, 1'b0, 1'b0);

        // Async reset mid-stream with a full, stalled pipe.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            rand_beat();
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'(0));
        check("rst_async_y", 64'(out_y), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        n0 = n_out;
        repeat (5) @(posedge clk);
        #1;
        check("rst_quiet", 64'(n_out - n0), 64'(0));
        run_latency("post_rst", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Randomized traffic with random back-pressure and occasional flush.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            rand_beat();
            @(posedge clk); #1;
        end
        flush = 1'b0;
        wait_drain("random_drain", 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
